// File: rtl/ym_write_sequencer.sv
// ym_write_sequencer
//
// Queued register-write sequencer for a dual YM2149 (TurboSound) pair.
// CPU-side (chip, register, data) requests go into a small FIFO. An FSM
// drains the FIFO onto the shared AY bus. Each write has these steps:
//   - an optional chip-select settle gap,
//   - a BC1/BDIR address-latch phase and its gap,
//   - a BDIR data-write phase and its gap.
// Phase and gap lengths are programmable. Software can therefore write at
// cpu_clock rate without violating YM bus timing.
//
// Optional feature, macro YM_ADDR_CACHE_EN:
//   Each chip remembers the last register index it latched. When a write
//   targets that register again, the address phase and its gap are skipped.
//
// Parameters
//   FIFO_DEPTH  request FIFO entries (power of two, 2..16)
//   PHASE_CYC   cycles BDIR is held high per phase (1..15)
//   GAP_CYC     idle cycles after each phase and after a chip switch (1..15)
//
// Ports
//   cpu_clock   in   sole clock, rising edge
//   reset       in   asynchronous, active-low reset
//   req_valid   in   write request present
//   req_ready   out  FIFO can accept (not full)
//   req_chip    in   target chip 0/1
//   req_reg     in   YM register index
//   req_data    in   value to write
//   busy        out  FIFO non-empty or sequencer active
//   ym_da       out  DA bus value
//   ym_da_oe    out  DA bus drive enable
//   bc1, bdir   out  YM bus control
//   ym_0, ym_1  out  chip selects (ym_1 = selected chip, ym_0 = its inverse)

module ym_write_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PHASE_CYC  = 2,
    parameter int GAP_CYC    = 1
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_chip,
    input  logic [3:0] req_reg,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic [7:0] ym_da,
    output logic       ym_da_oe,
    output logic       bc1,
    output logic       bdir,
    output logic       ym_0,
    output logic       ym_1
);

    localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    PHASE_LD = 4'(PHASE_CYC - 1);
    localparam logic [3:0]    GAP_LD   = 4'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_ADDR, S_AGAP, S_DATA, S_DGAP
    } state_t;

    state_t        state, next_state, start_state;
    logic [3:0]    cnt;
    logic          cnt_zero;

    logic [12:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    // Entry the FSM will work on after this edge. When the head is popped,
    // this is the following entry.
    logic [12:0]   nxt_entry;
    logic          nxt_chip;
    logic [3:0]    nxt_reg;
    logic [7:0]    nxt_data;
    logic          nxt_avail;
    logic          nxt_hit;

    logic          ym_sel;
    logic          bc1_d, bdir_d, oe_d, sel_d;
    logic [7:0]    da_d;

    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign cnt_zero  = (cnt == 4'd0);
    assign pop       = (state == S_DGAP) && cnt_zero;

    assign nxt_entry = pop ? fifo_mem[rd_ptr + AW'(1)] : fifo_mem[rd_ptr];
    assign nxt_avail = pop ? (count > CW'(1)) : (count != '0);
    assign nxt_chip  = nxt_entry[12];
    assign nxt_reg   = nxt_entry[11:8];
    assign nxt_data  = nxt_entry[7:0];

    assign busy = (count != '0) || (state != S_IDLE);
    assign ym_1 = ym_sel;
    assign ym_0 = ~ym_sel;

    // FIFO storage (data only, not reset)
    always_ff @(posedge cpu_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_chip, req_reg, req_data};
        end
    end

    // FIFO pointers / occupancy
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef YM_ADDR_CACHE_EN
    logic [1:0][3:0] cache_reg;
    logic [1:0]      cache_vld;

    // The register latched into the selected chip is recorded as the
    // address phase completes.
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            cache_reg <= '0;
            cache_vld <= '0;
        end else if ((state == S_ADDR) && cnt_zero) begin
            cache_reg[ym_sel] <= nxt_reg;
            cache_vld[ym_sel] <= 1'b1;
        end
    end

    assign nxt_hit = cache_vld[nxt_chip] && (cache_reg[nxt_chip] == nxt_reg);
`else
    assign nxt_hit = 1'b0;
`endif

    // First state of a write for the upcoming entry
    always_comb begin
        if (nxt_chip != ym_sel) begin
            start_state = S_SEL;
        end else if (nxt_hit) begin
            start_state = S_DATA;
        end else begin
            start_state = S_ADDR;
        end
    end

    // State register and phase counter
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= ((next_state == S_ADDR) || (next_state == S_DATA)) ? PHASE_LD : GAP_LD;
            end else if (!cnt_zero) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (nxt_avail) next_state = start_state;
            S_SEL:  if (cnt_zero)  next_state = nxt_hit ? S_DATA : S_ADDR;
            S_ADDR: if (cnt_zero)  next_state = S_AGAP;
            S_AGAP: if (cnt_zero)  next_state = S_DATA;
            S_DATA: if (cnt_zero)  next_state = S_DGAP;
            S_DGAP: if (cnt_zero)  next_state = nxt_avail ? start_state : S_IDLE;
            default:               next_state = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the bus pins come straight from flops
    always_comb begin
        bc1_d  = 1'b0;
        bdir_d = 1'b0;
        oe_d   = 1'b1;
        da_d   = ym_da;
        sel_d  = ym_sel;
        case (next_state)
            S_IDLE: oe_d = 1'b0;
            S_SEL: begin
                oe_d = 1'b0;
                if (state != S_SEL) sel_d = nxt_chip;
            end
            S_ADDR: begin
                bc1_d  = 1'b1;
                bdir_d = 1'b1;
                da_d   = {4'b0000, nxt_reg};
            end
            S_DATA: begin
                bdir_d = 1'b1;
                da_d   = nxt_data;
            end
            S_AGAP, S_DGAP: ;
            default: oe_d = 1'b0;
        endcase
    end

    // Registered bus outputs
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            bc1      <= 1'b0;
            bdir     <= 1'b0;
            ym_da_oe <= 1'b0;
            ym_da    <= 8'h00;
            ym_sel   <= 1'b0;
        end else begin
            bc1      <= bc1_d;
            bdir     <= bdir_d;
            ym_da_oe <= oe_d;
            ym_da    <= da_d;
            ym_sel   <= sel_d;
        end
    end

endmodule

// File: tb/tb_ym_write_sequencer.sv
// tb_ym_write_sequencer
//
// Bench for ym_write_sequencer. The model treats the YM pair as the bus
// slave would see it. Each chip keeps its latched address. A data strobe
// writes (chip, latched address, DA). Accepted requests queue the
// (chip, reg, data) write they must eventually produce.
// Optional feature macro YM_ADDR_CACHE_EN enables the address-skip checks.

module tb_ym_write_sequencer;

    localparam int D = 4;
    localparam int P = 2;
    localparam int G = 1;
`ifdef YM_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       cpu_clock = 1'b0;
    logic       reset     = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_chip  = 1'b0;
    logic [3:0] req_reg   = 4'h0;
    logic [7:0] req_data  = 8'h00;
    logic       busy;
    logic [7:0] ym_da;
    logic       ym_da_oe, bc1, bdir, ym_0, ym_1;

    int errors = 0;
    int checks = 0;

    logic [12:0] exp_q[$];
    bit          spacing_en = 1'b0;
    int          lat_total  = 0;

    ym_write_sequencer #(.FIFO_DEPTH(D), .PHASE_CYC(P), .GAP_CYC(G)) dut (
        .cpu_clock(cpu_clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip),
        .req_reg(req_reg), .req_data(req_data), .busy(busy),
        .ym_da(ym_da), .ym_da_oe(ym_da_oe), .bc1(bc1), .bdir(bdir),
        .ym_0(ym_0), .ym_1(ym_1)
    );

    always #5 cpu_clock = ~cpu_clock;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    // One request cycle; reports whether the DUT will take it at the next edge
    task automatic drive_cycle(input bit v, input bit c, input logic [3:0] r,
                               input logic [7:0] d, output bit acc);
        @(posedge cpu_clock);
        #1;
        req_valid = v;
        req_chip  = c;
        req_reg   = r;
        req_data  = d;
        @(negedge cpu_clock);
        acc = v && req_ready;
        if (acc) exp_q.push_back({c, r, d});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge cpu_clock);
        check("idle_timeout", int'(busy), 0);
    endtask

    // Bus monitor / scoreboard
    initial begin
        logic [3:0]  lat [2];
        logic [1:0]  cvld;
        logic [3:0]  creg [2];
        logic [12:0] e;
        int  cur_t, prev_t, run_len, lat_since, cyc, last_cyc;
        bit  gap_vld, last_vld, prev_busy, prev_oe, hit;
        lat[0] = 4'h0; lat[1] = 4'h0;
        creg[0] = 4'h0; creg[1] = 4'h0;
        cvld = 2'b00;
        prev_t = 0; run_len = 0; lat_since = 0; cyc = 0; last_cyc = 0;
        gap_vld = 0; last_vld = 0; prev_busy = 0; prev_oe = 0;
        forever begin
            @(negedge cpu_clock);
            if (!reset) begin
                cvld = 2'b00; prev_t = 0; run_len = 0; lat_since = 0;
                gap_vld = 0; last_vld = 0; prev_busy = 0; prev_oe = 0;
            end else begin
                cyc++;
                cur_t = bdir ? (bc1 ? 2 : 1) : 0;
                if (bc1) check("bc1_without_bdir", int'(bdir), 1);
                if (bdir) check("oe_during_strobe", int'(ym_da_oe), 1);
                if (prev_busy && !busy) check("busy_oe_fall", int'({prev_oe, ym_da_oe}), 2);
                if (cur_t != prev_t) begin
                    if (prev_t != 0) begin
                        check("phase_len", run_len, P);
                        gap_vld = 1;
                    end else if (gap_vld) begin
                        checks++;
                        if (run_len < G) begin
                            errors++;
                            $display("FAIL gap_len: got=%0d expected>=%0d", run_len, G);
                        end
                    end
                    run_len = 1;
                    if (cur_t == 2) begin
                        check("addr_upper_zero", int'(ym_da[7:4]), 0);
                        lat[ym_1] = ym_da[3:0];
                        lat_since++;
                        lat_total++;
                    end else if (cur_t == 1) begin
                        check("chip_sel_pair", int'({ym_1, ym_0}), int'({ym_1, ~ym_1}));
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: got=0x%0h expected=none",
                                     {ym_1, lat[ym_1], ym_da});
                        end else begin
                            e = exp_q.pop_front();
                            check("write", int'({ym_1, lat[ym_1], ym_da}), int'(e));
                            hit = CACHE && cvld[e[12]] && (creg[e[12]] == e[11:8]);
                            check("addr_latches", lat_since, hit ? 0 : 1);
                            cvld[e[12]] = 1'b1;
                            creg[e[12]] = e[11:8];
                            if (spacing_en && last_vld)
                                check("write_spacing", cyc - last_cyc, 2 * P + 2 * G);
                            last_vld = 1;
                            last_cyc = cyc;
                        end
                        lat_since = 0;
                    end
                end else begin
                    run_len++;
                end
                if (!busy) last_vld = 0;
                prev_t    = cur_t;
                prev_busy = busy;
                prev_oe   = ym_da_oe;
            end
        end
    end

    // Stimulus and directed checks
    initial begin
        bit acc;
        int acc_n, want, got, lat0;
        bit found, saw;

        // reset state
        repeat (3) @(negedge cpu_clock);
        check("reset_state", int'({bdir, bc1, ym_da_oe, ym_0, ym_1, req_ready, busy, ym_da}),
              int'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}));
        reset = 1'b1;

        // single write, cycle-by-cycle bus shape
        drive_cycle(1, 0, 4'd7, 8'h3F, acc);
        check("single_accept", int'(acc), 1);
        @(posedge cpu_clock);
        #1 req_valid = 1'b0;
        for (int k = 0; k <= 2 * P + 2 * G + 1; k++) begin
            @(negedge cpu_clock);
            want = {(k >= 1 && k <= P) || (k > P + G && k <= 2 * P + G),
                    (k >= 1 && k <= P),
                    (k >= 1 && k <= 2 * P + 2 * G),
                    (k <= 2 * P + 2 * G),
                    (k == 0) ? 8'h00 : ((k <= P + G) ? 8'h07 : 8'h3F)};
            got = {bdir, bc1, ym_da_oe, busy, ym_da};
            check($sformatf("single_k%0d", k), got, want);
        end

        // chip switch
        drive_cycle(1, 1, 4'd8, 8'h0F, acc);
        @(posedge cpu_clock);
        #1 req_valid = 1'b0;
        @(negedge cpu_clock);
        for (int k = 1; k <= G; k++) begin
            @(negedge cpu_clock);
            check("sel_gap", int'({ym_1, bdir}), 2);
        end
        @(negedge cpu_clock);
        check("sel_then_addr", int'({ym_1, bdir, bc1, ym_da}), int'({3'b111, 8'h08}));
        wait_idle();
        check("chip1_held", int'({ym_1, ym_0}), 2);

        // fill the FIFO with back-to-back requests
        spacing_en = 1'b1;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 0, 4'(9 + i), 8'($urandom), acc);
            acc_n += int'(acc);
            if (i == 4) check("ready_low_full", int'(req_ready), 0);
        end
        drive_cycle(0, 0, 4'd0, 8'd0, acc);
        check("fill_accepted", acc_n, D);
        wait_idle();
        spacing_en = 1'b0;

        // randomized traffic
        for (int i = 0; i < 300; i++)
            drive_cycle(($urandom % 2) == 1, ($urandom % 2) == 1,
                        4'($urandom % 4), 8'($urandom), acc);
        drive_cycle(0, 0, 4'd0, 8'd0, acc);
        wait_idle();

        // asynchronous reset during a data phase
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 4'(i + 1), 8'(8'hA0 + i), acc);
        drive_cycle(0, 0, 4'd0, 8'd0, acc);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge cpu_clock);
            #1;
            if (bdir && !bc1) begin
                found = 1;
                break;
            end
        end
        check("data_phase_seen", int'(found), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset", int'({bdir, bc1, ym_da_oe, ym_0, ym_1, req_ready, busy, ym_da}),
              int'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}));
        exp_q.delete();
        repeat (3) @(negedge cpu_clock);
        reset = 1'b1;
        saw = 0;
        repeat (30) begin
            @(negedge cpu_clock);
            if (bdir || busy) saw = 1;
        end
        check("no_bus_after_reset", int'(saw), 0);

`ifdef YM_ADDR_CACHE_EN
        // address cache: repeated register skips the address phase
        lat0 = lat_total;
        drive_cycle(1, 0, 4'd2, 8'h11, acc);
        drive_cycle(1, 0, 4'd2, 8'h22, acc);
        drive_cycle(1, 0, 4'd3, 8'h33, acc);
        drive_cycle(0, 0, 4'd0, 8'd0, acc);
        wait_idle();
        check("cache_latch_count", lat_total - lat0, 2);
`else
        lat0 = lat_total;
        drive_cycle(1, 0, 4'd2, 8'h11, acc);
        drive_cycle(1, 0, 4'd2, 8'h22, acc);
        drive_cycle(0, 0, 4'd0, 8'd0, acc);
        wait_idle();
        check("no_cache_latch_count", lat_total - lat0, 2);
`endif

        repeat (4) @(negedge cpu_clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ym_write_sequencer.md
# ym_write_sequencer

Queued register-write sequencer for the dual YM2149 (TurboSound) pair. Accepts (chip, register, data) write requests through a small FIFO and drives the shared AY bus: chip select, BC1/BDIR address-latch and data-write phases with programmable phase and gap lengths, and the DA bus with its output enable. It sits between the port-decode/CPU side and the YM pins, so software writes never violate YM bus timing at cpu_clock rate.

## Interface
- FIFO_DEPTH, 4: request FIFO entries; power of two, 2..16.
- PHASE_CYC, 2: cycles BDIR is held high per phase; 1..15.
- GAP_CYC, 1: inactive cycles (BC1=BDIR=0) after each phase and after a chip switch; 1..15.

- cpu_clock  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_chip  in  1  target chip: 0 or 1.
- req_reg  in  4  YM register index 0..15.
- req_data  in  8  value to write.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- ym_da  out  8  DA bus value.
- ym_da_oe  out  1  DA bus drive enable.
- bc1  out  1  YM BC1.
- bdir  out  1  YM BDIR.
- ym_0  out  1  equals ~ym_sel.
- ym_1  out  1  equals ym_sel (ym_sel: registered selected chip).

## Operation
- Push on rising edge with req_valid & req_ready; {chip,reg,data} stored (13 bits). req_valid while !req_ready is ignored (no overwrite, no stall of the FSM).
- req_ready derived from count only; when full, a same-cycle pop does not enable a push.
- FSM states: IDLE, SEL, ADDR, AGAP, DATA, DGAP. Head entry = FIFO read port.
- IDLE: if non-empty → SEL when head.chip != ym_sel, else ADDR (or DATA, see Configuration).
- SEL: ym_sel <= head.chip on entry; BC1=BDIR=0, oe=0; stay GAP_CYC cycles → ADDR.
- ADDR: BC1=1, BDIR=1, ym_da={4'b0,head.reg}, oe=1; PHASE_CYC cycles → AGAP.
- AGAP: BC1=BDIR=0, ym_da holds reg, oe=1; GAP_CYC cycles → DATA.
- DATA: BC1=0, BDIR=1, ym_da=head.data, oe=1; PHASE_CYC cycles → DGAP.
- DGAP: BC1=BDIR=0, ym_da holds data, oe=1; GAP_CYC cycles; on last cycle pop head; next state chosen from following entry as in IDLE if count>1, else IDLE.
- Single 4-bit down-counter loaded on every state entry with (len-1); transition when zero.
- Outputs bc1, bdir, ym_da, ym_da_oe, ym_sel are registered (no combinational path from req_*).
- BC1 never high while BDIR low; BDIR never high in SEL.

## Timing
- Reset values: bc1=0, bdir=0, ym_da=0, ym_da_oe=0, ym_sel=0 (ym_0=1, ym_1=0), req_ready=1, busy=0, FIFO empty, state IDLE.
- Reset asserted mid-write: all outputs return to reset values immediately (asynchronously); queued entries discarded.
- Latency, same chip, default params: request accepted at edge E0; ADDR outputs visible after E1 (bdir/bc1 high E1..E3), AGAP E3..E4, DATA E4..E6, DGAP E6..E7, oe low after E7 if empty.
- Cost per write: 2·PHASE_CYC+2·GAP_CYC cycles (6 default); +GAP_CYC when chip changes. Back-to-back entries: no IDLE cycle between writes.
- busy falls on the same edge ym_da_oe falls for the last entry.

## Configuration
- YM_ADDR_CACHE_EN defined: per-chip 4-bit last-latched register plus valid bit (cleared by reset, set on leaving ADDR). When entering a write whose head.reg equals the valid cached reg of head.chip, ADDR and AGAP are skipped (IDLE/SEL/DGAP → DATA). Write cost drops to PHASE_CYC+GAP_CYC.
- Not defined: ADDR phase issued for every write; no cache storage.

## Test plan
- Reset: hold reset low → bc1=bdir=0, oe=0, ym_0=1, ym_1=0, req_ready=1, busy=0.
- Single write chip0 reg 7 data 0x3F, defaults → BDIR high 2 cycles with BC1=1 and ym_da=0x07, 1-cycle gap, BDIR high 2 cycles BC1=0 ym_da=0x3F, busy low after 7 cycles.
- Chip switch: write chip1 reg 8 data 0x0F → ym_1 rises, 1 gap cycle with bdir=0 before ADDR; ym_1 stays 1 afterwards.
- Fill FIFO: 6 back-to-back requests, FIFO_DEPTH=4 → req_ready low after 4 accepted (5th/6th dropped unless ready), 4 writes issued in order, 6-cycle spacing, no idle between.
- Reset mid-DATA phase → bdir drops asynchronously, remaining entries never appear on the bus.
- With YM_ADDR_CACHE_EN: two writes chip0 reg 2 (0x11, 0x22) → first has ADDR phase, second only DATA phase (ym_da=0x22); reg 3 next → ADDR reappears.
